// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin / fixed-select output mux.
package mux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Select width is clog2(n), but never narrower than one bit.
    function automatic int calc_sel_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_rr_n_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH  = 32,
    parameter int SEL_W = 5
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    localparam int unsigned NCH = N_CH;

    int unsigned idx;

    // Scan from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned i = NCH; i >= 1; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (req[idx[SEL_W-1:0]]) begin
                grant_idx = idx[SEL_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel to one registered output mux with fixed-select and round-robin modes.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter  int N_CH  = 32,
    parameter  int WIDTH = 32,
    localparam int SEL_W = calc_sel_w(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned NCH = N_CH;

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_vld;
    logic [SEL_W-1:0]  g;
    logic              g_vld;
    logic              load_en;
    logic              xfer;
    int unsigned       g_base;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    always_comb begin
        g     = '0;
        g_vld = 1'b0;
        if (mode) begin
            g     = rr_idx;
            g_vld = rr_vld;
        end else if (int'(sel) < NCH) begin
            g     = sel;
            g_vld = in_valid[sel];
        end
    end

    assign load_en = (state == EMPTY) || out_ready;
    assign xfer    = g_vld && load_en && !rst;
    assign g_base  = int'(g) * WIDTH;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[g] = 1'b1;
    end

    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   if (xfer) state_n = FULL;
            FULL:    if (out_ready) state_n = xfer ? FULL : EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= SEL_W'(N_CH - 1);
            out_data <= '0;
            out_ch   <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                out_data <= in_data[g_base +: WIDTH];
                out_ch   <= g;
                if (mode) ptr <= g;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n at the default size and at N_CH=5, WIDTH=8.
module tb_mux_rr_n;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration: N_CH=32, WIDTH=32, SEL_W=5
    logic         rst;
    logic [1023:0] in_data;
    logic [31:0]  in_valid;
    logic [31:0]  in_ready;
    logic         mode;
    logic [4:0]   sel;
    logic [31:0]  out_data;
    logic [4:0]   out_ch;
    logic         out_valid;
    logic         out_ready;

    // Small configuration: N_CH=5, WIDTH=8, SEL_W=3
    logic         rst5;
    logic [39:0]  in_data5;
    logic [4:0]   in_valid5;
    logic [4:0]   in_ready5;
    logic         mode5;
    logic [2:0]   sel5;
    logic [7:0]   out_data5;
    logic [2:0]   out_ch5;
    logic         out_valid5;
    logic         out_ready5;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    mux_rr_n #(.N_CH(32), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_n #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst(rst5), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
        .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '1;
        out_ready = 1'b1;
        mode = 1'b0;
        sel = 5'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
            checks++;
            if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", out_data); end
            checks++;
            if (out_ch !== 5'd0) begin errors++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
            checks++;
            if (in_ready !== 32'd0) begin errors++; $display("FAIL reset_ready got=%0h exp=0", in_ready); end
        end
        rst = 1'b0;
        in_valid = '0;
        #1;
    endtask

    task automatic test_fixed();
        int sels[5] = '{0, 1, 31, 23, 11};
        exp_t e;
        mode = 1'b0;
        out_ready = 1'b1;
        in_valid = '1;
        for (int i = 0; i < 5; i++) begin
            sel = 5'(sels[i]);
            #1;
            checks++;
            if (in_ready !== (32'd1 << sels[i])) begin
                errors++; $display("FAIL fixed_ready got=%0h exp=%0h", in_ready, 32'd1 << sels[i]);
            end
            q.push_back('{ch: sels[i], data: sels[i]});
            step();
            checks++;
            if (q.size() == 0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL fixed_valid got=%0b exp=1", out_valid);
            end else begin
                e = q.pop_front();
                if (int'(out_ch) !== e.ch || out_data !== 32'(e.data)) begin
                    errors++; $display("FAIL fixed_out got ch=%0d data=%0h exp ch=%0d data=%0h", out_ch, out_data, e.ch, e.data);
                end
            end
        end
        in_valid = '0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_round_robin();
        int seq[5] = '{3, 7, 30, 3, 7};
        exp_t e;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mode = 1'b1;
        out_ready = 1'b1;
        in_valid = '0;
        in_valid[3] = 1'b1;
        in_valid[7] = 1'b1;
        in_valid[30] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q.push_back('{ch: seq[i], data: seq[i]});
            step();
            checks++;
            if (q.size() == 0 || out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_valid got=%0b exp=1", out_valid);
            end else begin
                e = q.pop_front();
                if (int'(out_ch) !== e.ch || out_data !== 32'(e.data)) begin
                    errors++; $display("FAIL rr_out got ch=%0d data=%0h exp ch=%0d data=%0h", out_ch, out_data, e.ch, e.data);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 32'd0) begin errors++; $display("FAIL bp_ready got=%0h exp=0", in_ready); end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 5'd7 || out_data !== 32'd7) begin
                errors++; $display("FAIL bp_hold got v=%0b ch=%0d data=%0h exp v=1 ch=7 data=7", out_valid, out_ch, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== (32'd1 << 30)) begin errors++; $display("FAIL bp_release_ready got=%0h exp=%0h", in_ready, 32'd1 << 30); end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 5'd30 || out_data !== 32'd30) begin
            errors++; $display("FAIL bp_release got v=%0b ch=%0d data=%0h exp v=1 ch=30 data=30", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_fixed_no_grant();
        mode = 1'b0;
        sel = 5'd5;
        in_valid = 32'd1 << 3;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 32'd0) begin errors++; $display("FAIL nogrant_ready got=%0h exp=0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL nogrant_drain got=%0b exp=0", out_valid); end
        end
    endtask

    task automatic test_small();
        int seq[7] = '{0, 1, 2, 3, 4, 0, 1};
        exp_t e;
        for (int k = 0; k < 5; k++) in_data5[k*8 +: 8] = 8'(8'hA0 + k);
        rst5 = 1'b1;
        mode5 = 1'b0;
        sel5 = 3'd6;
        in_valid5 = '1;
        out_ready5 = 1'b1;
        step();
        rst5 = 1'b0;
        #1;
        checks++;
        if (in_ready5 !== 5'd0) begin errors++; $display("FAIL small_sel6_ready got=%0h exp=0", in_ready5); end
        step();
        checks++;
        if (out_valid5 !== 1'b0) begin errors++; $display("FAIL small_sel6_valid got=%0b exp=0", out_valid5); end

        mode5 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            q.push_back('{ch: seq[i], data: 8'hA0 + seq[i]});
            step();
            checks++;
            if (q.size() == 0 || out_valid5 !== 1'b1) begin
                errors++; $display("FAIL small_rr_valid got=%0b exp=1", out_valid5);
            end else begin
                e = q.pop_front();
                if (int'(out_ch5) !== e.ch || int'(out_data5) !== e.data) begin
                    errors++; $display("FAIL small_rr_out got ch=%0d data=%0h exp ch=%0d data=%0h", out_ch5, out_data5, e.ch, e.data);
                end
            end
        end

        rst5 = 1'b1;
        #1;
        checks++;
        if (in_ready5 !== 5'd0) begin errors++; $display("FAIL small_rst_ready got=%0h exp=0", in_ready5); end
        step();
        checks++;
        if (out_valid5 !== 1'b0 || out_ch5 !== 3'd0 || out_data5 !== 8'd0) begin
            errors++; $display("FAIL small_rst_out got v=%0b ch=%0d data=%0h exp v=0 ch=0 data=0", out_valid5, out_ch5, out_data5);
        end
        rst5 = 1'b0;
        #1;
        checks++;
        if (in_ready5 !== 5'b00001) begin errors++; $display("FAIL small_ptr_ready got=%0b exp=00001", in_ready5); end
        step();
        checks++;
        if (out_valid5 !== 1'b1 || out_ch5 !== 3'd0 || out_data5 !== 8'hA0) begin
            errors++; $display("FAIL small_ptr_out got v=%0b ch=%0d data=%0h exp v=1 ch=0 data=a0", out_valid5, out_ch5, out_data5);
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) in_data[k*32 +: 32] = k;
        rst5 = 1'b1;
        in_data5 = '0;
        in_valid5 = '0;
        mode5 = 1'b0;
        sel5 = '0;
        out_ready5 = 1'b0;
        #1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_fixed_no_grant();
        test_small();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
